// File: rtl/l1_miss_request_arbiter_pkg.sv
// Shared defines for the L1 miss request path to L2.
// Types, widths and packet encodings used by the arbiter and its bench.
package l1_miss_request_arbiter_pkg;
   localparam int THREADS_PER_CORE = 4;
   localparam int MAX_OUTSTANDING = 2 * THREADS_PER_CORE;
   localparam int CACHE_LINE_INDEX_W = 26;

   typedef logic [CACHE_LINE_INDEX_W-1:0] cache_line_index_t;
   typedef logic [$clog2(THREADS_PER_CORE)-1:0] l1_miss_entry_idx_t;
   typedef logic [1:0] core_id_t;

   typedef enum logic {
      UNIT_ICACHE = 1'b0,
      UNIT_DCACHE = 1'b1
   } cache_unit_t;

   typedef enum logic [1:0] {
      L2REQ_LOAD       = 2'd0,
      L2REQ_STORE      = 2'd1,
      L2REQ_LOAD_SYNC  = 2'd2,
      L2REQ_STORE_SYNC = 2'd3
   } l2req_packet_type_t;

   typedef struct packed {
      core_id_t           core;
      l1_miss_entry_idx_t id;
      cache_unit_t        unit;
      l2req_packet_type_t packet_type;
      cache_line_index_t  address;
   } l2req_packet_t;
endpackage

// File: rtl/l1_miss_request_arbiter_if.sv
// Miss-queue dequeue ports, L2 request handshake and response retire bus.
// slave is the arbiter side, master the miss queues / L2 side.
interface l1_miss_request_arbiter_if;
   import l1_miss_request_arbiter_pkg::*;

   logic               icache_dequeue_ready;
   cache_line_index_t  icache_dequeue_addr;
   l1_miss_entry_idx_t icache_dequeue_idx;
   logic               icache_dequeue_ack;

   logic               dcache_dequeue_ready;
   cache_line_index_t  dcache_dequeue_addr;
   l1_miss_entry_idx_t dcache_dequeue_idx;
   logic               dcache_dequeue_sync;
   logic               dcache_dequeue_ack;

   logic               l2i_request_valid;
   logic               l2i_request_ready;
   l2req_packet_t      l2i_request;

   logic               l2_response_valid;
   cache_unit_t        l2_response_unit;

   logic [3:0]         outstanding_count;

   modport slave (
      input  icache_dequeue_ready,
      input  icache_dequeue_addr,
      input  icache_dequeue_idx,
      output icache_dequeue_ack,
      input  dcache_dequeue_ready,
      input  dcache_dequeue_addr,
      input  dcache_dequeue_idx,
      input  dcache_dequeue_sync,
      output dcache_dequeue_ack,
      output l2i_request_valid,
      input  l2i_request_ready,
      output l2i_request,
      input  l2_response_valid,
      input  l2_response_unit,
      output outstanding_count
   );

   modport master (
      output icache_dequeue_ready,
      output icache_dequeue_addr,
      output icache_dequeue_idx,
      input  icache_dequeue_ack,
      output dcache_dequeue_ready,
      output dcache_dequeue_addr,
      output dcache_dequeue_idx,
      output dcache_dequeue_sync,
      input  dcache_dequeue_ack,
      input  l2i_request_valid,
      output l2i_request_ready,
      input  l2i_request,
      output l2_response_valid,
      output l2_response_unit,
      input  outstanding_count
   );
endinterface

// File: rtl/l1_miss_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: the requester after the last winner has priority.
// The last-winner index only moves when update_lru is asserted.
module rr_arbiter #(
   parameter int NUM_REQUESTERS = 2,
   localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic                      update_lru,
   output logic [NUM_REQUESTERS-1:0] grant_oh
);
   logic [IDX_W-1:0] last;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] cand;
   logic             found;
   int               k;

   always_comb begin
      grant_oh = '0;
      grant_idx = last;
      cand = '0;
      found = 1'b0;
      k = 0;
      for (int i = 1; i <= NUM_REQUESTERS; i++) begin
         k = (int'(last) + i) % NUM_REQUESTERS;
         cand = IDX_W'(k);
         if (!found && request[cand]) begin
            found = 1'b1;
            grant_oh[cand] = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Index 0 counts as last winner out of reset, so index 1 goes first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= '0;
      end else if (update_lru) begin
         last <= grant_idx;
      end
   end
endmodule

// File: rtl/l1_miss_request_arbiter.sv
// Arbitrates icache/dcache miss-queue heads into a single registered L2
// request slot and tracks how many loads are outstanding at L2.
module l1_miss_request_arbiter
   import l1_miss_request_arbiter_pkg::*;
#(
   parameter core_id_t CORE_ID = '0
) (
   input logic                    clk,
   input logic                    reset,
   l1_miss_request_arbiter_if.slave bus
);
   logic          accept;
   logic          transfer;
   logic [1:0]    request;
   logic [1:0]    grant_oh;
   logic          grant_valid;
   logic          slot_valid;
   l2req_packet_t slot;
   l2req_packet_t next_req;
   logic [3:0]    count;

   assign transfer = slot_valid && bus.l2i_request_ready;
   assign accept = reset && (!slot_valid || bus.l2i_request_ready);
   assign request = {bus.dcache_dequeue_ready, bus.icache_dequeue_ready}
                  & {2{accept}};
   assign grant_valid = |grant_oh;

   rr_arbiter #(
      .NUM_REQUESTERS(2)
   ) u_rr (
      .clk        (clk),
      .reset      (reset),
      .request    (request),
      .update_lru (grant_valid),
      .grant_oh   (grant_oh)
   );

   assign bus.icache_dequeue_ack = grant_oh[0];
   assign bus.dcache_dequeue_ack = grant_oh[1];

   always_comb begin
      next_req.core = CORE_ID;
      next_req.id = bus.icache_dequeue_idx;
      next_req.unit = UNIT_ICACHE;
      next_req.packet_type = L2REQ_LOAD;
      next_req.address = bus.icache_dequeue_addr;
      if (grant_oh[1]) begin
         next_req.id = bus.dcache_dequeue_idx;
         next_req.unit = UNIT_DCACHE;
         next_req.address = bus.dcache_dequeue_addr;
         if (bus.dcache_dequeue_sync) begin
            next_req.packet_type = L2REQ_LOAD_SYNC;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_valid <= 1'b0;
      end else if (accept) begin
         slot_valid <= grant_valid;
      end
   end

   // Payload is qualified by slot_valid, so it needs no reset
   always_ff @(posedge clk) begin
      if (grant_valid) begin
         slot <= next_req;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         unique case ({transfer, bus.l2_response_valid})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   assign bus.l2i_request_valid = slot_valid;
   assign bus.l2i_request = slot;
   assign bus.outstanding_count = count;

   a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(bus.l2_response_valid && !transfer && count == 4'd0));

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(transfer && !bus.l2_response_valid
        && count == 4'(MAX_OUTSTANDING)));

   a_one_ack: assert property (@(posedge clk) disable iff (!reset)
      $onehot0({bus.icache_dequeue_ack, bus.dcache_dequeue_ack}));

   a_resp_unit: assert property (@(posedge clk) disable iff (!reset)
      bus.l2_response_valid |->
         (bus.l2_response_unit inside {UNIT_ICACHE, UNIT_DCACHE}));
endmodule
